// File: rtl/data_mem_mp_if.sv
// Per-port request/grant/response bus of the multi-port data memory.
// Port p occupies slice p of every vector (addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] etc).
interface data_mem_mp_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            req_i;
    logic [NUM_PORTS-1:0]            we_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS*BYTES-1:0]      be_i;
    logic [NUM_PORTS-1:0]            gnt_o;
    logic [NUM_PORTS-1:0]            rsp_valid_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o;
    logic [NUM_PORTS-1:0]            err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rsp_valid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rsp_valid_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_mem_mp.sv
// Multi-port byte-enabled data memory with registered read data, error
// responses and a one-word-per-cycle init sweep after reset.
module data_mem_mp #(
    parameter int unsigned           NUM_PORTS  = 2,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 256,
    parameter int unsigned           READ_MODE  = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_mp_if.slave  bus,
    output logic          init_done_o
);
    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned OFFS   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [MEM_AW-1:0]     LAST_WORD = MEM_AW'(MEM_DEPTH - 1);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                          state;
    logic [MEM_AW-1:0]               cnt;
    logic [DATA_WIDTH-1:0]           mem [MEM_DEPTH];

    logic [NUM_PORTS-1:0]            gnt;
    logic [NUM_PORTS-1:0]            bad;
    logic [NUM_PORTS-1:0]            wr_ok;
    logic [ADDR_WIDTH-1:0]           addr  [NUM_PORTS];
    logic [ADDR_WIDTH-1:0]           widx  [NUM_PORTS];
    logic [MEM_AW-1:0]               wa    [NUM_PORTS];
    logic [DATA_WIDTH-1:0]           wdat  [NUM_PORTS];
    logic [BYTES-1:0]                be    [NUM_PORTS];
    logic [DATA_WIDTH-1:0]           rd_word [NUM_PORTS];

    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [NUM_PORTS-1:0]            err;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdata;

    always_comb begin
        gnt = (state == S_READY) ? bus.req_i : '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            addr[p]  = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            wdat[p]  = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            be[p]    = bus.be_i[p*BYTES +: BYTES];
            widx[p]  = addr[p] >> OFFS;
            bad[p]   = ((addr[p] & OFF_MASK) != '0) || ({1'b0, widx[p]} >= DEPTH_EXT);
            wa[p]    = widx[p][MEM_AW-1:0];
            wr_ok[p] = gnt[p] & bus.we_i[p] & ~bad[p];
        end
    end

    // Write-through view: apply this cycle's writes highest port first so the
    // lowest port index ends up owning any contested byte lane.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rd_word[p] = mem[wa[p]];
            if (READ_MODE == 1) begin
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (wr_ok[NUM_PORTS-1-i] && (wa[NUM_PORTS-1-i] == wa[p])) begin
                        for (int unsigned b = 0; b < BYTES; b++) begin
                            if (be[NUM_PORTS-1-i][b])
                                rd_word[p][8*b +: 8] = wdat[NUM_PORTS-1-i][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Array has no reset; same priority order as the write-through view.
    always_ff @(posedge clk) begin
        if (state == S_INIT && rst_n)
            mem[cnt] <= INIT_VALUE;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (wr_ok[NUM_PORTS-1-i]) begin
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (be[NUM_PORTS-1-i][b])
                        mem[wa[NUM_PORTS-1-i]][8*b +: 8] <= wdat[NUM_PORTS-1-i][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            cnt         <= '0;
            init_done_o <= 1'b0;
            rsp_valid   <= '0;
            err         <= '0;
            rdata       <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == LAST_WORD) begin
                        state       <= S_READY;
                        init_done_o <= 1'b1;
                    end else begin
                        cnt <= cnt + MEM_AW'(1);
                    end
                end
                S_READY: state <= S_READY;
                default: state <= S_INIT;
            endcase
            rsp_valid <= gnt;
            err       <= gnt & bad;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p])
                    rdata[p*DATA_WIDTH +: DATA_WIDTH] <=
                        (bad[p] || bus.we_i[p]) ? '0 : rd_word[p];
            end
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.err_o       = err;
    assign bus.rdata_o     = rdata;
endmodule

// File: tb/tb_data_mem_mp.sv
// Randomized bench for data_mem_mp: a read-first and a write-through instance
// share stimulus and are checked against a word-array reference model.
module tb_data_mem_mp;
    localparam int NP = 2;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int BY = 4;
    localparam int DEPTH = 256;
    localparam logic [DW-1:0] IV0 = 32'h0000_0000;
    localparam logic [DW-1:0] IV1 = 32'hA5A5_0F0F;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    req = '0;
    logic [NP-1:0]    we = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [NP*BY-1:0] be = '0;
    logic done0, done1;

    data_mem_mp_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    data_mem_mp_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.req_i = req;   assign bus1.req_i = req;
    assign bus0.we_i = we;     assign bus1.we_i = we;
    assign bus0.addr_i = addr; assign bus1.addr_i = addr;
    assign bus0.wdata_i = wdata; assign bus1.wdata_i = wdata;
    assign bus0.be_i = be;     assign bus1.be_i = be;

    data_mem_mp #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                  .READ_MODE(0), .INIT_VALUE(IV0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .init_done_o(done0));
    data_mem_mp #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                  .READ_MODE(1), .INIT_VALUE(IV1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .init_done_o(done1));

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] m [2][DEPTH];
    logic [DW-1:0] hold_rd [2][NP];
    int ready_cnt = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", tag, act, exp);
        end
    endtask

    function automatic bit bad_a(input logic [AW-1:0] a);
        return ((int'(a) % BY) != 0) || ((int'(a) / BY) >= DEPTH);
    endfunction

    task automatic set_port(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BY-1:0] b);
        req[p] = r;
        we[p] = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        be[p*BY +: BY] = b;
    endtask

    task automatic rand_ports();
        for (int p = 0; p < NP; p++) begin
            int k;
            logic [AW-1:0] a;
            k = $urandom_range(0, 9);
            if (k < 7)      a = AW'($urandom_range(0, 7) * 4);
            else if (k < 9) a = AW'($urandom_range(0, DEPTH - 1) * 4);
            else            a = AW'($urandom);
            set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                     $urandom, BY'($urandom));
        end
    endtask

    // One clock: inputs already driven; model the cycle, then compare responses.
    task automatic step();
        bit rdy;
        logic [NP-1:0] g, ee;
        logic [DW-1:0] nm [2][DEPTH];
        logic [NP*DW-1:0] r0, r1;
        rdy = (ready_cnt >= DEPTH);
        g = rdy ? req : '0;
        #2;
        check("gnt_m0", 64'(bus0.gnt_o), 64'(g));
        check("gnt_m1", 64'(bus1.gnt_o), 64'(g));
        check("done_m0", 64'(done0), 64'(rdy));
        check("done_m1", 64'(done1), 64'(rdy));
        nm = m;
        ee = '0;
        for (int p = 0; p < NP; p++) begin
            logic [AW-1:0] a;
            a = addr[p*AW +: AW];
            if (g[p] && bad_a(a)) ee[p] = 1'b1;
            if (g[p] && we[p] && !bad_a(a)) begin
                for (int b = 0; b < BY; b++) begin
                    bit lower;
                    lower = 1'b0;
                    for (int q = 0; q < p; q++)
                        if (g[q] && we[q] && !bad_a(addr[q*AW +: AW]) &&
                            addr[q*AW +: AW] == a && be[q*BY + b])
                            lower = 1'b1;
                    if (be[p*BY + b] && !lower)
                        for (int d = 0; d < 2; d++)
                            nm[d][int'(a) / BY][8*b +: 8] = wdata[p*DW + 8*b +: 8];
                end
            end
        end
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < NP; p++)
                if (g[p]) begin
                    logic [AW-1:0] a;
                    a = addr[p*AW +: AW];
                    if (bad_a(a) || we[p]) hold_rd[d][p] = '0;
                    else if (d == 0)       hold_rd[d][p] = m[d][int'(a) / BY];
                    else                   hold_rd[d][p] = nm[d][int'(a) / BY];
                end
        @(posedge clk);
        #1;
        r0 = {hold_rd[0][1], hold_rd[0][0]};
        r1 = {hold_rd[1][1], hold_rd[1][0]};
        check("vld_m0", 64'(bus0.rsp_valid_o), 64'(g));
        check("vld_m1", 64'(bus1.rsp_valid_o), 64'(g));
        check("err_m0", 64'(bus0.err_o & g), 64'(ee));
        check("err_m1", 64'(bus1.err_o & g), 64'(ee));
        check("rdata_m0", 64'(bus0.rdata_o), 64'(r0));
        check("rdata_m1", 64'(bus1.rdata_o), 64'(r1));
        m = nm;
        ready_cnt++;
        if (ready_cnt == DEPTH)
            for (int i = 0; i < DEPTH; i++) begin
                m[0][i] = IV0;
                m[1][i] = IV1;
            end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 64'({bus0.gnt_o, bus1.gnt_o}), 64'(0));
        check({tag, "_vld"}, 64'({bus0.rsp_valid_o, bus1.rsp_valid_o}), 64'(0));
        check({tag, "_err"}, 64'({bus0.err_o, bus1.err_o}), 64'(0));
        check({tag, "_rd0"}, 64'(bus0.rdata_o), 64'(0));
        check({tag, "_rd1"}, 64'(bus1.rdata_o), 64'(0));
        check({tag, "_done"}, 64'({done0, done1}), 64'(0));
    endtask

    // Called at posedge+1: drop reset mid-cycle with requests held high.
    task automatic async_reset(input string tag);
        req = '1;
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready_cnt = 0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < NP; p++) hold_rd[d][p] = '0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < NP; p++) hold_rd[d][p] = '0;
        #1 rst_n = 1'b0;
        req = '1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            req = '1;
            we = NP'($urandom);
            step();
        end

        set_port(0, 1, 0, 11'h3FC, '0, '0); set_port(1, 0, 0, '0, '0, '0);
        step();
        check("rd3fc_data", 64'(bus0.rdata_o[31:0]), 64'h0);
        check("rd3fc_err", 64'(bus0.err_o[0]), 64'h0);

        set_port(0, 1, 1, 11'h010, 32'hDEADBEEF, 4'hF);
        step();
        set_port(0, 0, 0, '0, '0, '0); set_port(1, 1, 0, 11'h010, '0, '0);
        step();
        check("rd010_p1", 64'(bus0.rdata_o[63:32]), 64'hDEADBEEF);

        set_port(0, 1, 1, 11'h020, 32'h11111111, 4'b0011);
        set_port(1, 1, 1, 11'h020, 32'h22222222, 4'b0110);
        step();
        set_port(0, 1, 0, 11'h020, '0, '0); set_port(1, 0, 0, '0, '0, '0);
        step();
        check("merge020", 64'(bus0.rdata_o[31:0]), 64'h00221111);

        set_port(0, 1, 1, 11'h040, 32'hAAAAAAAA, 4'hF);
        step();
        set_port(0, 1, 1, 11'h040, 32'h55555555, 4'hF); set_port(1, 1, 0, 11'h040, '0, '0);
        step();
        check("rfirst040", 64'(bus0.rdata_o[63:32]), 64'hAAAAAAAA);
        check("wthru040", 64'(bus1.rdata_o[63:32]), 64'h55555555);

        set_port(0, 1, 0, 11'h402, '0, '0); set_port(1, 0, 0, '0, '0, '0);
        step();
        check("misalign_err", 64'({bus0.err_o[0], bus0.rsp_valid_o[0]}), 64'h3);
        set_port(0, 1, 0, 11'h400, '0, '0);
        step();
        check("range_err", 64'({bus0.err_o[0], bus0.rsp_valid_o[0]}), 64'h3);
        check("range_rd", 64'(bus0.rdata_o[31:0]), 64'h0);

        repeat (500) begin rand_ports(); step(); end

        async_reset("rst_ready");
        for (int i = 0; i < 100; i++) begin rand_ports(); step(); end
        async_reset("rst_init");
        for (int i = 0; i < DEPTH; i++) begin rand_ports(); step(); end
        repeat (300) begin rand_ports(); step(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/data_mem_mp.md
Name: data_mem_mp

Overview:
- Multi-port, byte-enabled, synchronous-read data memory; next generation of the core's dual-port data RAM.
- Generalised in port count, data width and depth.
- Adds per-port req/gnt/response handshake, registered read data, and error responses.
- Replaces the one-cycle array-wide reset clear with a sequenced init sweep.
- Sits between the RISC-V load/store unit(s), the encryption co-processor DMA port and the data address space.

Parameters:
- NUM_PORTS, 2: number of independent access ports; 1..4.
- ADDR_WIDTH, 10: byte-address width per port.
- DATA_WIDTH, 32: word width; multiple of 8; BYTES = DATA_WIDTH/8.
- MEM_DEPTH, 256: words; must be <= 2^(ADDR_WIDTH - log2(BYTES)).
- READ_MODE, 0:
  - 0: read-first; a same-cycle write is not visible to a read.
  - 1: write-through; read data reflects same-cycle writes from all ports after byte merge.
- INIT_VALUE, 0: word value written to every location by the init sweep.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_i, in, NUM_PORTS: per-port request.
- we_i, in, NUM_PORTS: per-port write (1) / read (0).
- addr_i, in, NUM_PORTS*ADDR_WIDTH: byte addresses; port p in slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i, in, NUM_PORTS*DATA_WIDTH: write data.
- be_i, in, NUM_PORTS*BYTES: byte enables; bit b selects byte lane [8b+7:8b].
- gnt_o, out, NUM_PORTS: request accepted this cycle.
- rsp_valid_o, out, NUM_PORTS: response for the request accepted in the previous cycle.
- rdata_o, out, NUM_PORTS*DATA_WIDTH: read data; valid only with rsp_valid_o and we=0.
- err_o, out, NUM_PORTS: response is an error; valid only with rsp_valid_o.
- init_done_o, out, 1: memory initialised and accepting requests.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state INIT and init counter 0.
  - gnt_o, rsp_valid_o, rdata_o, err_o and init_done_o all read 0 while reset is asserted.
  - The memory array is not cleared by the reset itself.
- FSM state INIT:
  - One word written per cycle: word[cnt] <= INIT_VALUE, then cnt++.
  - After writing word MEM_DEPTH-1, go to READY.
  - Takes exactly MEM_DEPTH cycles after rst_n deasserts.
  - gnt_o = 0 throughout; requests are ignored and masters hold them.
- FSM state READY:
  - init_done_o = 1.
  - gnt_o[p] = req_i[p] (combinational); every request is accepted in one cycle, no backpressure.
  - READY exits only via reset.
- Reset mid-INIT: sweep restarts from word 0; partially swept contents are don't-care.
- Word index: widx = addr >> log2(BYTES).
- Address checks:
  - Misaligned: addr low log2(BYTES) bits != 0.
  - Out of range: widx >= MEM_DEPTH.
- Accepted write:
  - Updates each enabled byte lane at the grant edge.
  - be = 0 is a legal no-op.
  - Response next cycle: rsp_valid=1, err=0, rdata=0.
- Accepted read:
  - rdata_o registered; latency exactly 1 cycle (grant edge -> rsp_valid high for 1 cycle).
  - rdata_o holds its value until the next response on that port.
- Error request (misaligned or out of range):
  - No array access.
  - Next cycle: rsp_valid=1, err=1, rdata=0.
- Back-to-back requests on one port: one response per cycle, in order.
- Write conflict: when several ports write the same byte of the same word in one cycle, the lowest port index wins, per byte lane.
- Non-overlapping byte lanes from different ports to the same word all take effect.
- Read/write same cycle, same word: result follows READ_MODE; never X.
- rsp_valid_o drops to 0 in any cycle following no grant.

Test Plan:
- Defaults. Release reset, hold req_i=2'b11 -> gnt_o=0 for exactly 256 cycles; init_done_o rises on cycle 256. A read of addr 0x3FC then returns 0x00000000, err=0, one cycle after grant.
- Port0 writes 0xDEADBEEF to 0x010 with be=4'hF. Next cycle port1 reads 0x010 -> rdata_o[63:32]=0xDEADBEEF one cycle later.
- Same cycle, both ports write 0x020: port0 data 0x11111111 be=4'b0011, port1 data 0x22222222 be=4'b0110. Readback -> 0x00221111 (port0 wins lane 1).
- READ_MODE=0 vs 1: word 0x040 holds 0xAAAAAAAA; port0 writes 0x55555555 while port1 reads 0x040. Required response: 0xAAAAAAAA (mode 0) or 0x55555555 (mode 1).
- Port0 reads 0x402 (misaligned) then 0x400 (out of range, widx 256) -> two consecutive responses with err=1, rdata=0; memory unchanged.
- Assert rst_n low at INIT cycle 100 -> all outputs 0 immediately. After release, init_done_o rises exactly 256 cycles later.
